// File: rtl/core_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package core_pkg;

    // Loader frame-parser states.
    typedef enum logic [2:0] {
        LD_WAIT_MAGIC,
        LD_HDR_LO,
        LD_HDR_HI,
        LD_PAYLOAD,
        LD_CHECK,
        LD_DONE,
        LD_ERR
    } loader_state_e;

    // First byte of every load frame.
    localparam logic [7:0] LOADER_MAGIC = 8'hA5;

    // Width of the word-count field in the frame header.
    localparam int LOADER_LEN_WIDTH = 16;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit little-endian words; byte k of a word
// lands in bits [8k+7:8k]. word_valid_o strobes alongside the 4th byte so
// the caller can register the complete word on that same edge.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_q, word_d;

    // Lane counter / partial-word assembly; the top byte is never stored,
    // it is merged combinationally into the outgoing word.
    always_comb begin
        lane_d       = lane_q;
        word_d       = word_q;
        word_valid_o = 1'b0;
        word_o       = {byte_i, word_q};
        if (clear_i) begin
            lane_d = 2'd0;
            word_d = '0;
        end else if (byte_valid_i) begin
            if (lane_q == 2'd3) begin
                word_valid_o = 1'b1;
                lane_d       = 2'd0;
                word_d       = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                case (lane_q)
                    2'd0:    word_d[7:0]   = byte_i;
                    2'd1:    word_d[15:8]  = byte_i;
                    default: word_d[23:16] = byte_i;
                endcase
            end
        end
    end

    // Partial-word state; reset discards any half-assembled word.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes the payload into
// instruction memory from word 0 and releases the core only after the
// frame checksum matches.
module imem_loader
    import core_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid_i,
    input  logic [7:0]                 rx_data_i,
    output logic                       rx_ready_o,
    output logic                       imem_we_o,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0]      imem_wdata_o,
    output logic                       core_rst_n_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    // Largest word count that fits in memory without wrapping onto word 0.
    localparam logic [LOADER_LEN_WIDTH:0] LEN_MAX = (LOADER_LEN_WIDTH+1)'(2 ** IMEM_ADDR_WIDTH);

    loader_state_e                 state_q, state_d;
    logic [LOADER_LEN_WIDTH-1:0]   len_q, len_d;
    logic [LOADER_LEN_WIDTH-1:0]   word_cnt_q, word_cnt_d;
    logic [7:0]                    chk_q, chk_d;
    logic [IMEM_ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                          we_q, we_d;
    logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
    logic                          rx_ready_q, rx_ready_d;

    logic                          accept;
    logic                          restart;
    logic [LOADER_LEN_WIDTH-1:0]   hdr_len;
    logic                          pk_word_valid;
    logic [31:0]                   pk_word;

    assign accept  = rx_valid_i && rx_ready_q;
    assign hdr_len = {rx_data_i, len_q[7:0]};
    assign restart = accept && (rx_data_i == LOADER_MAGIC) &&
                     ((state_q == LD_WAIT_MAGIC) || (state_q == LD_DONE) || (state_q == LD_ERR));

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (restart),
        .byte_valid_i (accept && (state_q == LD_PAYLOAD)),
        .byte_i       (rx_data_i),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    // Frame parser: next state, counters, checksum and write strobe.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        chk_d      = chk_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        rx_ready_d = 1'b1;

        // The address steps only after the write cycle has used it.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        if (accept) begin
            case (state_q)
                LD_WAIT_MAGIC, LD_DONE, LD_ERR: begin
                    if (restart) begin
                        state_d    = LD_HDR_LO;
                        addr_d     = '0;
                        chk_d      = '0;
                        word_cnt_d = '0;
                    end
                end
                LD_HDR_LO: begin
                    len_d[7:0] = rx_data_i;
                    state_d    = LD_HDR_HI;
                end
                LD_HDR_HI: begin
                    len_d[15:8] = rx_data_i;
                    if ({1'b0, hdr_len} > LEN_MAX) begin
                        state_d = LD_ERR;
                    end else if (hdr_len == '0) begin
                        state_d = LD_CHECK;
                    end else begin
                        state_d = LD_PAYLOAD;
                    end
                end
                LD_PAYLOAD: begin
                    chk_d = chk_q ^ rx_data_i;
                    if (pk_word_valid) begin
                        we_d       = 1'b1;
                        wdata_d    = pk_word;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_d == len_q) begin
                            state_d = LD_CHECK;
                        end
                    end
                end
                LD_CHECK: begin
                    state_d = (rx_data_i == chk_q) ? LD_DONE : LD_ERR;
                end
                default: state_d = LD_WAIT_MAGIC;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LD_WAIT_MAGIC;
            len_q      <= '0;
            word_cnt_q <= '0;
            chk_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            chk_q      <= chk_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = (state_q == LD_HDR_LO) || (state_q == LD_HDR_HI) ||
                          (state_q == LD_PAYLOAD) || (state_q == LD_CHECK);
    assign done_o       = (state_q == LD_DONE);
    assign core_rst_n_o = (state_q == LD_DONE);
    assign err_o        = (state_q == LD_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan
// followed by randomized frames checked against a frame-level model.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid_i;
    logic [7:0]    rx_data_i;
    logic          rx_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic          core_rst_n_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    imem_loader #(.DATA_WIDTH(32), .IMEM_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rst_n_o (core_rst_n_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    int          pulses  = 0;
    logic [31:0] dut_mem [0:WORDS-1];
    logic [31:0] exp_mem [0:WORDS-1];
    logic [7:0]  pl [$];

    // Observed memory: everything the DUT writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we_o === 1'b1) begin
            pulses = pulses + 1;
            dut_mem[imem_addr_o] = imem_wdata_o;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one byte (after an optional idle gap); returns at the
    // negedge following acceptance with rx_valid_i still high.
    task automatic push(input logic [7:0] b, input int gap);
        if (gap > 0) begin
            rx_valid_i = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd0);
        check({tag, "_we"},       64'(imem_we_o), 64'd0);
        check({tag, "_addr"},     64'(imem_addr_o), 64'd0);
        check({tag, "_wdata"},    64'(imem_wdata_o), 64'd0);
        check({tag, "_core_rst"}, 64'(core_rst_n_o), 64'd0);
        check({tag, "_busy"},     64'(busy_o), 64'd0);
        check({tag, "_done"},     64'(done_o), 64'd0);
        check({tag, "_err"},      64'(err_o), 64'd0);
    endtask

    // Send one frame of n words using payload pl; chk_mask != 0 corrupts CHK.
    // The model: words are pl packed little-endian, written to 0..n-1 one
    // cycle after each 4th byte; outcome is DONE iff n fits and CHK matches.
    task automatic run_frame(input string tag, input int n, input logic [7:0] chk_mask,
                             input int gap, input bit skip_magic);
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        int          p0 = pulses;
        int          bad = 0;
        bit          ok;
        if (!skip_magic) begin
            push(8'hA5, gap);
            check({tag, "_magic_busy"}, 64'(busy_o), 64'd1);
            check({tag, "_magic_err"},  64'(err_o), 64'd0);
            check({tag, "_magic_done"}, 64'(done_o), 64'd0);
        end
        push(8'(n), gap);
        push(8'(n >> 8), gap);
        if (n > WORDS) begin
            rx_valid_i = 1'b0;
            check({tag, "_oversize_err"},  64'(err_o), 64'd1);
            check({tag, "_oversize_core"}, 64'(core_rst_n_o), 64'd0);
            check({tag, "_oversize_nowr"}, 64'(pulses - p0), 64'd0);
            $display("frame %s n=%0d oversize err=%0d", tag, n, err_o);
            return;
        end
        for (int j = 0; j < 4 * n; j++) begin
            push(pl[j], gap);
            x ^= pl[j];
            if (j % 4 == 3) begin
                w = {pl[j], pl[j-1], pl[j-2], pl[j-3]};
                exp_mem[j/4] = w;
                check({tag, "_we"},    64'(imem_we_o), 64'd1);
                check({tag, "_addr"},  64'(imem_addr_o), 64'(j / 4));
                check({tag, "_wdata"}, 64'(imem_wdata_o), 64'(w));
            end else begin
                check({tag, "_nowe"}, 64'(imem_we_o), 64'd0);
            end
        end
        push(x ^ chk_mask, gap);
        rx_valid_i = 1'b0;
        ok = (chk_mask == 8'h00);
        check({tag, "_done"},   64'(done_o), 64'(ok));
        check({tag, "_err"},    64'(err_o), 64'(!ok));
        check({tag, "_core"},   64'(core_rst_n_o), 64'(ok));
        check({tag, "_busy"},   64'(busy_o), 64'd0);
        check({tag, "_pulses"}, 64'(pulses - p0), 64'(n));
        for (int i = 0; i < n; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
        check({tag, "_mem"}, 64'(bad), 64'd0);
        $display("frame %s n=%0d gap=%0d chk_ok=%0d done=%0d err=%0d writes=%0d",
                 tag, n, gap, ok, done_o, err_o, pulses - p0);
    endtask

    initial begin
        int          p0;
        int          n;
        int          gap;
        logic [7:0]  mask;
        logic [7:0]  b;
        logic [31:0] w0;

        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(rx_ready_o), 64'd1);

        // Garbage before MAGIC is ignored.
        push(8'h00, 0); check("garbage00_busy", 64'(busy_o), 64'd0);
        push(8'hFF, 0); check("garbageFF_busy", 64'(busy_o), 64'd0);
        push(8'h5A, 0); check("garbage5A_busy", 64'(busy_o), 64'd0);
        rx_valid_i = 1'b0;
        check("garbage_nowr", 64'(pulses), 64'd0);

        // Reference N=2 image.
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("load2", 2, 8'h00, 0, 1'b0);
        check("load2_word0", 64'(dut_mem[0]), 64'h0000_0013);
        check("load2_word1", 64'(dut_mem[1]), 64'h0010_0093);
        run_frame("badchk", 2, 8'h01, 0, 1'b0);
        run_frame("after_bad", 2, 8'h00, 0, 1'b0);

        // Oversize header, then empty frame.
        pl.delete();
        run_frame("oversize", WORDS + 1, 8'h00, 0, 1'b0);
        run_frame("empty", 0, 8'h00, 0, 1'b0);

        // 1-of-3 valid cycles during the frame.
        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("gaps", 2, 8'h00, 2, 1'b0);

        // Reset after 6 payload bytes: only word 0 written.
        fill_random(2);
        w0 = {pl[3], pl[2], pl[1], pl[0]};
        p0 = pulses;
        push(8'hA5, 0); push(8'h02, 0); push(8'h00, 0);
        for (int j = 0; j < 6; j++) push(pl[j], 0);
        rx_valid_i = 1'b0;
        check("midload_one_write", 64'(pulses - p0), 64'd1);
        check("midload_word0", 64'(dut_mem[0]), 64'(w0));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midload_rst");
        rst = 1'b0;
        @(negedge clk);
        check("midload_no_partial", 64'(pulses - p0), 64'd1);
        fill_random(2);
        run_frame("after_rst", 2, 8'h00, 0, 1'b0);

        // MAGIC while DONE restarts the load and re-holds the core.
        push(8'hA5, 0);
        rx_valid_i = 1'b0;
        check("reload_core_rst", 64'(core_rst_n_o), 64'd0);
        check("reload_done",     64'(done_o), 64'd0);
        check("reload_busy",     64'(busy_o), 64'd1);
        fill_random(3);
        run_frame("reload", 3, 8'h00, 0, 1'b1);

        // Largest frame that fits.
        fill_random(WORDS);
        run_frame("full", WORDS, 8'h00, 0, 1'b0);

        // Randomized frames with garbage, gaps, corruption and oversize.
        for (int it = 0; it < 24; it++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                push(b, 0);
                check("rand_garbage_nowe", 64'(imem_we_o), 64'd0);
            end
            rx_valid_i = 1'b0;
            n    = int'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) n = WORDS + 1 + int'($urandom_range(0, 3000));
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            gap  = int'($urandom_range(0, 2));
            if (n <= WORDS) fill_random(n);
            run_frame("rand", n, mask, gap, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
